// File: rtl/serv_decode_seq_pkg.sv
// Shared encodings for the serial decode sequencer: FSM states, opcode[6:2]
// values and the immediate-format select codes driven on o_ctrl.
package serv_decode_seq_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_RFREQ = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [3:0] CTRL_I = 4'b1010;
  localparam logic [3:0] CTRL_S = 4'b1011;
  localparam logic [3:0] CTRL_B = 4'b1101;
  localparam logic [3:0] CTRL_U = 4'b1000;
  localparam logic [3:0] CTRL_J = 4'b0000;

  // Unlisted opcodes fall back to the I-type shift pattern.
  function automatic logic [3:0] ctrl_decode(input logic [4:0] op);
    case (op)
      OP_STORE:          return CTRL_S;
      OP_BRANCH:         return CTRL_B;
      OP_AUIPC, OP_LUI:  return CTRL_U;
      OP_JAL:            return CTRL_J;
      default:           return CTRL_I;
    endcase
  endfunction

endpackage

// File: rtl/serv_decode_seq_cnt.sv
// 5-bit serial bit counter: advances while running and not stalled, flags
// the bit-31 cycle and wraps to 0 on it.
module serv_seq_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_stall,
  output logic [4:0] o_cnt,
  output logic       o_cnt_en,
  output logic       o_cnt_done
);

  assign o_cnt_en   = i_run & ~i_stall;
  assign o_cnt_done = (o_cnt == 5'd31) & o_cnt_en;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= 5'd0;
    end else if (o_cnt_en) begin
      o_cnt <= o_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/serv_decode_seq.sv
// Fetch / register-read / 32-cycle serial run sequencer with immediate-format
// decode for the downstream immediate shift network.
module serv_decode_seq
  import serv_decode_seq_pkg::*;
#(
  parameter int WITH_CSR = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_ibus_cyc,
  input  logic        i_ibus_ack,
  input  logic [31:0] i_ibus_rdt,
  output logic        o_wb_en,
  output logic [3:0]  o_ctrl,
  output logic        o_csr_imm_en,
  output logic        o_rf_rreq,
  input  logic        i_rf_ready,
  input  logic        i_stall,
  output logic        o_cnt_en,
  output logic [4:0]  o_cnt,
  output logic        o_cnt_done
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       armed;
  logic       csr_imm_d;
  logic [4:0] opcode;
  logic       rdt_unused;

  assign opcode     = i_ibus_rdt[6:2];
  assign rdt_unused = ^{i_ibus_rdt[31:15], i_ibus_rdt[13:7], i_ibus_rdt[1:0]};

  // armed keeps the fetch request low until the first edge after reset release.
  assign o_ibus_cyc = armed & (state == ST_FETCH);
  assign o_wb_en    = o_ibus_cyc & i_ibus_ack;
  assign o_rf_rreq  = (state == ST_RFREQ);

  generate
    if (WITH_CSR != 0) begin : g_csr
      assign csr_imm_d = (opcode == OP_SYSTEM) & i_ibus_rdt[14];
    end else begin : g_no_csr
      assign csr_imm_d = 1'b0;
    end
  endgenerate

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (o_wb_en)    state_nxt = ST_RFREQ;
      ST_RFREQ: if (i_rf_ready) state_nxt = ST_RUN;
      ST_RUN:   if (o_cnt_done) state_nxt = ST_FETCH;
      default:                  state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_FETCH;
      armed        <= 1'b0;
      o_ctrl       <= 4'b0000;
      o_csr_imm_en <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (o_wb_en) begin
        o_ctrl       <= ctrl_decode(opcode);
        o_csr_imm_en <= csr_imm_d;
      end
    end
  end

  // Counter sits at 0 on RUN entry: it wraps on done and clears on reset.
  serv_seq_cnt u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (state == ST_RUN),
    .i_stall    (i_stall),
    .o_cnt      (o_cnt),
    .o_cnt_en   (o_cnt_en),
    .o_cnt_done (o_cnt_done)
  );

endmodule

// File: tb/tb_serv_decode_seq.sv
// Directed scenario bench for serv_decode_seq; a second instance with
// WITH_CSR = 0 shares all inputs to check the CSR-immediate tie-off.
module tb_serv_decode_seq;

  logic        clk = 1'b0;
  logic        rst_n, ack, rf_ready, stall;
  logic [31:0] rdt;

  logic        cyc, wb_en, csr, rreq, cnt_en, done;
  logic [3:0]  ctrl;
  logic [4:0]  cnt;

  logic        nc_cyc, nc_wb_en, nc_csr, nc_rreq, nc_cnt_en, nc_done;
  logic [3:0]  nc_ctrl;
  logic [4:0]  nc_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] W_ADDI = 32'h00500093;
  localparam logic [31:0] W_SW   = 32'h0050A023;
  localparam logic [31:0] W_BEQ  = 32'h00000063;
  localparam logic [31:0] W_JAL  = 32'h0000006F;

  always #5 clk = ~clk;

  serv_decode_seq #(.WITH_CSR(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_ibus_cyc(cyc), .i_ibus_ack(ack),
    .i_ibus_rdt(rdt), .o_wb_en(wb_en), .o_ctrl(ctrl), .o_csr_imm_en(csr),
    .o_rf_rreq(rreq), .i_rf_ready(rf_ready), .i_stall(stall),
    .o_cnt_en(cnt_en), .o_cnt(cnt), .o_cnt_done(done)
  );

  serv_decode_seq #(.WITH_CSR(0)) dut_nc (
    .i_clk(clk), .i_rst_n(rst_n), .o_ibus_cyc(nc_cyc), .i_ibus_ack(ack),
    .i_ibus_rdt(rdt), .o_wb_en(nc_wb_en), .o_ctrl(nc_ctrl), .o_csr_imm_en(nc_csr),
    .o_rf_rreq(nc_rreq), .i_rf_ready(rf_ready), .i_stall(stall),
    .o_cnt_en(nc_cnt_en), .o_cnt(nc_cnt), .o_cnt_done(nc_done)
  );

  // All sampling and driving happens just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cyc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Acks w in the current FETCH cycle; returns in the following (RFREQ) cycle.
  task automatic issue(input logic [31:0] w);
    ack = 1'b1;
    rdt = w;
    tick();
    ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ack = 1'b1; rdt = W_ADDI; rf_ready = 1'b1; stall = 1'b0;
    tick();
    tick();
    checks++;
    if ({cyc, wb_en, rreq, cnt_en, done, csr} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000", {cyc, wb_en, rreq, cnt_en, done, csr});
    end
    checks++;
    if (cnt !== 5'd0 || ctrl !== 4'b0000) begin
      failures++;
      $display("FAIL reset_regs: got cnt=%0d ctrl=%b expected cnt=0 ctrl=0000", cnt, ctrl);
    end
    checks++;
    if ({nc_cyc, nc_wb_en, nc_rreq, nc_cnt_en, nc_done, nc_csr, nc_cnt, nc_ctrl} !== 15'b0) begin
      failures++;
      $display("FAIL reset_nc: got %b expected all zero",
               {nc_cyc, nc_wb_en, nc_rreq, nc_cnt_en, nc_done, nc_csr, nc_cnt, nc_ctrl});
    end
    ack = 1'b0; rf_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (cyc !== 1'b0) begin
      failures++;
      $display("FAIL release_no_cyc: got %b expected 0", cyc);
    end
    tick();
    checks++;
    if (cyc !== 1'b1) begin
      failures++;
      $display("FAIL first_cycle_cyc: got %b expected 1", cyc);
    end
  endtask

  task automatic test_fetch_addi();
    tick();
    ack = 1'b1; rdt = W_ADDI;
    #1;
    checks++;
    if (wb_en !== 1'b1) begin
      failures++;
      $display("FAIL addi_wb_en: got %b expected 1", wb_en);
    end
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if ({wb_en, cyc, rreq} !== 3'b001) begin
      failures++;
      $display("FAIL addi_rfreq: got wb/cyc/rreq=%b expected 001", {wb_en, cyc, rreq});
    end
    checks++;
    if (ctrl !== 4'b1010 || csr !== 1'b0) begin
      failures++;
      $display("FAIL addi_ctrl: got ctrl=%b csr=%b expected 1010 0", ctrl, csr);
    end
    tick();
    checks++;
    if (rreq !== 1'b1 || cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL rfreq_hold: got rreq=%b cnt_en=%b expected 1 0", rreq, cnt_en);
    end
  endtask

  task automatic test_run_nostall();
    int en_cnt = 0, dones = 0, done_cnt = -1, done_i = -1, cyc_i = -1;
    int seq_err = 0, excl_err = 0, ctrl_err = 0;
    rf_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (int'(cyc) + int'(rreq) + int'(cnt_en) > 1) excl_err++;
      if (cyc) begin
        cyc_i = i;
        break;
      end
      if (ctrl !== 4'b1010) ctrl_err++;
      if (cnt_en) begin
        if (cnt !== en_cnt[4:0]) seq_err++;
        en_cnt++;
      end
      if (done) begin
        dones++;
        done_cnt = int'(cnt);
        done_i = i;
      end
    end
    checks++;
    if (en_cnt != 32) begin
      failures++;
      $display("FAIL run_len: got %0d expected 32", en_cnt);
    end
    checks++;
    if (dones != 1 || done_cnt != 31) begin
      failures++;
      $display("FAIL run_done: got pulses=%0d at cnt=%0d expected 1 at 31", dones, done_cnt);
    end
    checks++;
    if (cyc_i < 0 || cyc_i != done_i + 1) begin
      failures++;
      $display("FAIL run_refetch: got cyc at %0d expected %0d", cyc_i, done_i + 1);
    end
    checks++;
    if (seq_err != 0 || excl_err != 0 || ctrl_err != 0) begin
      failures++;
      $display("FAIL run_integrity: got seq=%0d excl=%0d ctrl=%0d expected 0 0 0",
               seq_err, excl_err, ctrl_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [2];
    logic [3:0]  exps [2];
    int n;
    bit ok;
    words = '{W_SW, W_BEQ};
    exps  = '{4'b1011, 4'b1101};
    rf_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_fetch(ok);
      issue(words[k]);
      n = 1;
      while (!cyc && n < 100) begin
        tick();
        n++;
      end
      checks++;
      if (n != 34) begin
        failures++;
        $display("FAIL b2b_period%0d: got %0d expected 34", k, n);
      end
      checks++;
      if (ctrl !== exps[k]) begin
        failures++;
        $display("FAIL b2b_ctrl%0d: got %b expected %b", k, ctrl, exps[k]);
      end
    end
  endtask

  task automatic test_formats();
    logic [31:0] words [10];
    logic [3:0]  exps [10];
    logic        csrs [10];
    bit ok;
    words = '{32'h0050A023, 32'h00000063, 32'h000000B7, 32'h0000006F, 32'h00000033,
              32'h00000017, 32'h3002D0F3, 32'h00001073, 32'h00008067, 32'h0000A083};
    exps  = '{4'b1011, 4'b1101, 4'b1000, 4'b0000, 4'b1010,
              4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    csrs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rf_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_fetch(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fmt_fetch%0d: got no o_ibus_cyc expected fetch within 100 cycles", k);
      end
      issue(words[k]);
      checks++;
      if (ctrl !== exps[k] || nc_ctrl !== exps[k]) begin
        failures++;
        $display("FAIL fmt_ctrl%0d: got %b/%b expected %b", k, ctrl, nc_ctrl, exps[k]);
      end
      checks++;
      if (csr !== csrs[k] || nc_csr !== 1'b0) begin
        failures++;
        $display("FAIL fmt_csr%0d: got %b/%b expected %b/0", k, csr, nc_csr, csrs[k]);
      end
    end
  endtask

  task automatic test_stall();
    int run_cycles = 0, stalls = 0, dones = 0, bad = 0;
    bit fetched = 1'b0;
    bit ok;
    rf_ready = 1'b1;
    wait_fetch(ok);
    issue(W_ADDI);
    for (int i = 0; i < 100; i++) begin
      tick();
      stall = 1'b0;
      #1;
      if (cyc) begin
        fetched = 1'b1;
        break;
      end
      run_cycles++;
      if (cnt == 5'd31 && stalls < 3) begin
        stall = 1'b1;
        #1;
        stalls++;
        if (cnt_en !== 1'b0 || done !== 1'b0 || rreq !== 1'b0) bad++;
      end else if (done) begin
        dones++;
        if (cnt !== 5'd31) bad++;
      end
    end
    stall = 1'b0;
    checks++;
    if (!fetched || run_cycles != 35) begin
      failures++;
      $display("FAIL stall_len: got %0d run cycles (refetch=%0d) expected 35", run_cycles, fetched);
    end
    checks++;
    if (dones != 1 || stalls != 3 || bad != 0) begin
      failures++;
      $display("FAIL stall_done: got dones=%0d stalls=%0d bad=%0d expected 1 3 0", dones, stalls, bad);
    end
  endtask

  task automatic test_spurious();
    int err = 0;
    bit ok;
    wait_fetch(ok);
    rf_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({cyc, rreq, cnt_en} !== 3'b100) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL ready_in_fetch: got %0d bad cycles expected 0", err);
    end
    rf_ready = 1'b0;
    issue(W_ADDI);
    tick();
    ack = 1'b1; rdt = W_JAL;
    #1;
    checks++;
    if (rreq !== 1'b1 || wb_en !== 1'b0) begin
      failures++;
      $display("FAIL ack_in_rfreq: got rreq=%b wb_en=%b expected 1 0", rreq, wb_en);
    end
    rf_ready = 1'b1;
    tick();
    err = 0;
    for (int k = 0; k < 5; k++) begin
      if (wb_en !== 1'b0 || cnt !== 5'(k) || ctrl !== 4'b1010 || cyc !== 1'b0) err++;
      tick();
    end
    ack = 1'b0;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL ack_in_run: got %0d bad cycles expected 0", err);
    end
    wait_fetch(ok);
    checks++;
    if (!ok || ctrl !== 4'b1010) begin
      failures++;
      $display("FAIL ack_in_run_end: got refetch=%0d ctrl=%b expected 1 1010", ok, ctrl);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok, found = 1'b0;
    wait_fetch(ok);
    rf_ready = 1'b1;
    issue(W_SW);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cnt == 5'd17 && cnt_en) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrun_reach17: got no cnt=17 expected within 100 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, wb_en, rreq, cnt_en, done, csr, cnt, ctrl} !== 15'b0) begin
      failures++;
      $display("FAIL midrun_reset: got %b expected all zero",
               {cyc, wb_en, rreq, cnt_en, done, csr, cnt, ctrl});
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (cyc !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_release: got cyc=%b done=%b expected 0 0", cyc, done);
    end
    tick();
    checks++;
    if (cyc !== 1'b1 || cnt !== 5'd0 || rreq !== 1'b0) begin
      failures++;
      $display("FAIL midrun_restart: got cyc=%b cnt=%0d rreq=%b expected 1 0 0", cyc, cnt, rreq);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_addi();
    test_run_nostall();
    test_back_to_back();
    test_formats();
    test_stall();
    test_spurious();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
